// File: rtl/bram_loader.sv
// Streams bytes over valid/ready into a 512x8 iCE40-style block RAM from a programmed base address,
// with an independent registered read port over the same RAM.

package bram_loader_pkg;

  // In 512x8 mode the primitive carries byte bit i on data lane 2i; odd lanes are unused.
  function automatic logic [15:0] spread_byte(input logic [7:0] b);
    logic [15:0] w;
    w = 16'h0000;
    for (int i = 0; i < 8; i++) begin
      w[2*i] = b[i];
    end
    return w;
  endfunction

  function automatic logic [7:0] gather_byte(input logic [15:0] w);
    logic [7:0] b;
    b = 8'h00;
    for (int i = 0; i < 8; i++) begin
      b[i] = w[2*i];
    end
    return b;
  endfunction

endpackage

// Behavioural stand-in for SB_RAM40_4K in 512x8 mode (WRITE_MODE=1, READ_MODE=1).
module bram_loader_ram #(
  parameter logic [7:0] INIT_FILL = 8'h00
) (
  input  logic        clk_i,
  input  logic        we_i,
  input  logic [10:0] waddr_i,
  input  logic [15:0] wdata_i,
  input  logic [15:0] mask_i,
  input  logic        re_i,
  input  logic [10:0] raddr_i,
  output logic [15:0] rdata_o
);

  localparam logic [15:0] INIT_WORD = bram_loader_pkg::spread_byte(INIT_FILL);

  logic [15:0] mem_q [512] = '{default: INIT_WORD};
  logic        wsel_s;
  logic        rsel_s;

  // Only the low 512-entry window exists in this mode.
  assign wsel_s = we_i && (waddr_i[10:9] == 2'b00);
  assign rsel_s = (raddr_i[10:9] == 2'b00);

  // Write port: mask bits set to 1 preserve the stored bit.
  always_ff @(posedge clk_i) begin
    if (wsel_s) begin
      mem_q[waddr_i[8:0]] <= (mem_q[waddr_i[8:0]] & mask_i) | (wdata_i & ~mask_i);
    end
  end

  // Read port: registered, one clock of latency, contents not touched by reset.
  always_ff @(posedge clk_i) begin
    if (re_i) begin
      rdata_o <= rsel_s ? mem_q[raddr_i[8:0]] : 16'h0000;
    end
  end

endmodule

module bram_loader #(
  parameter logic [7:0] INIT_FILL = 8'h00,
  parameter int         ADDR_W    = 9
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [9:0]        length,
  input  logic              abort,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              busy,
  output logic              done,
  output logic [9:0]        count,
  input  logic [ADDR_W-1:0] raddr,
  output logic [7:0]        rdata
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] wptr_q, wptr_d;
  logic [9:0]        remaining_q, remaining_d;
  logic [9:0]        count_q, count_d;
  logic [9:0]        len_clamped_s;
  logic              accept_s;
  logic [15:0]       ram_rdata_s;

  // Lengths beyond the RAM depth are illegal; treat them as a full 512-byte load.
  assign len_clamped_s = (length > 10'd512) ? 10'd512 : length;
  assign accept_s      = (state_q == ST_LOAD) && in_valid && !abort;

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      wptr_q      <= '0;
      remaining_q <= 10'd0;
      count_q     <= 10'd0;
    end else begin
      state_q     <= state_d;
      wptr_q      <= wptr_d;
      remaining_q <= remaining_d;
      count_q     <= count_d;
    end
  end

  // Next-state logic; abort outranks both start and an offered byte.
  always_comb begin
    state_d     = state_q;
    wptr_d      = wptr_q;
    remaining_d = remaining_q;
    count_d     = count_q;
    case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          wptr_d      = base_addr;
          remaining_d = len_clamped_s;
          count_d     = 10'd0;
          state_d     = (len_clamped_s != 10'd0) ? ST_LOAD : ST_DONE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (in_valid) begin
          wptr_d      = wptr_q + 1'b1;
          count_d     = count_q + 10'd1;
          remaining_d = remaining_q - 10'd1;
          state_d     = (remaining_q == 10'd1) ? ST_DONE : ST_LOAD;
        end else begin
          state_d = ST_LOAD;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign in_ready = (state_q == ST_LOAD);
  assign busy     = (state_q == ST_LOAD) || (state_q == ST_DONE);
  assign done     = (state_q == ST_DONE);
  assign count    = count_q;

  bram_loader_ram #(
    .INIT_FILL(INIT_FILL)
  ) u_ram (
    .clk_i  (clk),
    .we_i   (accept_s),
    .waddr_i({2'b00, wptr_q}),
    .wdata_i(bram_loader_pkg::spread_byte(in_data)),
    .mask_i (16'h0000),
    .re_i   (1'b1),
    .raddr_i({2'b00, raddr}),
    .rdata_o(ram_rdata_s)
  );

  assign rdata = bram_loader_pkg::gather_byte(ram_rdata_s);

endmodule

// File: tb/tb_bram_loader.sv
// Directed plus randomized bench for bram_loader; a byte-array model of the RAM predicts every readback.

module tb_bram_loader;

  localparam logic [7:0] FILL = 8'h00;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [8:0] base_addr;
  logic [9:0] length;
  logic       abort;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       busy;
  logic       done;
  logic [9:0] count;
  logic [8:0] raddr;
  logic [7:0] rdata;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] ref_mem [512];
  logic [7:0] dq [$];

  bram_loader #(.INIT_FILL(FILL)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .base_addr(base_addr),
    .length   (length),
    .abort    (abort),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .busy     (busy),
    .done     (done),
    .count    (count),
    .raddr    (raddr),
    .rdata    (rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic rd(input logic [8:0] a);
    raddr = a;
    step();
    chk($sformatf("rdata[%0d]", a), {24'h0, rdata}, {24'h0, ref_mem[a]});
  endtask

  // One transfer. vpat_len>0 selects a repeating valid pattern, else valid_pct random.
  // abort_at>=0 aborts once that many bytes are accepted; start_mid fires a stray start mid-load.
  task automatic xfer(input logic [8:0] base, input logic [9:0] len, input int valid_pct,
                      input logic [15:0] vpat, input int vpat_len, input int abort_at,
                      input bit start_mid);
    int         eff;
    int         acc;
    int         cyc;
    int         bound;
    logic       v;
    logic [8:0] wp;
    eff   = (len > 10'd512) ? 512 : int'(len);
    acc   = 0;
    cyc   = 0;
    wp    = base;
    bound = 4 * eff + 64;
    start = 1'b1; base_addr = base; length = len; in_valid = 1'b0;
    step();
    start = 1'b0;
    if (eff == 0) begin
      chk("zl_done", {31'h0, done}, 32'd1);
      chk("zl_ready", {31'h0, in_ready}, 32'd0);
      chk("zl_count", {22'h0, count}, 32'd0);
      step();
      chk("zl_done_end", {31'h0, done}, 32'd0);
      chk("zl_busy_end", {31'h0, busy}, 32'd0);
      return;
    end
    while (acc < eff && cyc < bound) begin
      chk("in_ready", {31'h0, in_ready}, 32'd1);
      chk("count_run", {22'h0, count}, acc);
      if (acc == abort_at) begin
        abort = 1'b1; in_valid = 1'b1; in_data = 8'h55;
        step();
        abort = 1'b0; in_valid = 1'b0;
        chk("abort_busy", {31'h0, busy}, 32'd0);
        chk("abort_done", {31'h0, done}, 32'd0);
        chk("abort_count", {22'h0, count}, acc);
        step();
        chk("abort_no_done", {31'h0, done}, 32'd0);
        return;
      end
      if (vpat_len > 0) v = vpat[cyc % vpat_len];
      else              v = ($urandom_range(99) < valid_pct);
      in_valid = v;
      if (v && dq.size() > 0) in_data = dq.pop_front();
      else                    in_data = 8'($urandom);
      if (start_mid && acc == 1) begin
        start = 1'b1; base_addr = ~base; length = 10'd3;
      end
      step();
      start = 1'b0;
      if (v) begin
        ref_mem[wp] = in_data;
        wp++;
        acc++;
      end
      cyc++;
    end
    in_valid = 1'b0;
    if (cyc >= bound) begin
      chk("xfer_timeout", acc, eff);
      return;
    end
    if (vpat_len == 0 && valid_pct >= 100) chk("xfer_cycles", cyc, eff);
    chk("done_pulse", {31'h0, done}, 32'd1);
    chk("ready_after", {31'h0, in_ready}, 32'd0);
    chk("count_final", {22'h0, count}, eff);
    step();
    chk("done_once", {31'h0, done}, 32'd0);
    chk("busy_end", {31'h0, busy}, 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 512; i++) ref_mem[i] = FILL;
    rst_n = 1'b0; start = 1'b0; base_addr = 9'd0; length = 10'd0; abort = 1'b0;
    in_data = 8'h00; in_valid = 1'b0; raddr = 9'd0;
    repeat (2) @(negedge clk);
    chk("rst_ready", {31'h0, in_ready}, 32'd0);
    chk("rst_busy", {31'h0, busy}, 32'd0);
    chk("rst_done", {31'h0, done}, 32'd0);
    chk("rst_count", {22'h0, count}, 32'd0);
    rst_n = 1'b1;
    step();

    // Basic load of 0x00..0x0F at address 0, then readback.
    for (int i = 0; i < 16; i++) dq.push_back(8'(i));
    xfer(9'd0, 10'd16, 100, 16'h0, 0, -1, 1'b0);
    for (int a = 0; a < 16; a++) rd(9'(a));

    // Wrap from 510 with valid pattern 1,0,1,1,0,1.
    dq = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
    xfer(9'd510, 10'd4, 0, 16'b101101, 6, -1, 1'b0);
    rd(9'd510); rd(9'd511); rd(9'd0); rd(9'd1); rd(9'd2); rd(9'd509);

    // Zero length.
    xfer(9'd200, 10'd0, 100, 16'h0, 0, -1, 1'b0);
    rd(9'd200);

    // Abort after three accepts; address 35 must keep its prior contents.
    xfer(9'd32, 10'd8, 100, 16'h0, 0, 3, 1'b0);
    rd(9'd32); rd(9'd33); rd(9'd34); rd(9'd35);

    // start and abort together in IDLE.
    start = 1'b1; abort = 1'b1; base_addr = 9'd300; length = 10'd5;
    step();
    start = 1'b0; abort = 1'b0;
    chk("prio_busy", {31'h0, busy}, 32'd0);
    chk("prio_ready", {31'h0, in_ready}, 32'd0);
    step();
    chk("prio_done", {31'h0, done}, 32'd0);

    // Randomized transfers, some with a stray start while busy.
    for (int t = 0; t < 6; t++) begin
      xfer(9'($urandom), 10'($urandom_range(24, 1)), 70, 16'h0, 0, -1, (t % 2) == 1);
    end

    // Asynchronous reset mid-load.
    start = 1'b1; base_addr = 9'd100; length = 10'd10;
    step();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = 8'($urandom);
      step();
      ref_mem[9'd100 + 9'(i)] = in_data;
    end
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("arst_ready", {31'h0, in_ready}, 32'd0);
    chk("arst_busy", {31'h0, busy}, 32'd0);
    chk("arst_done", {31'h0, done}, 32'd0);
    chk("arst_count", {22'h0, count}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("arst_no_done", {31'h0, done}, 32'd0);
    for (int a = 100; a < 105; a++) rd(9'(a));

    // Over-length request clamps to a full 512-byte load.
    xfer(9'($urandom), 10'd700, 100, 16'h0, 0, -1, 1'b0);
    for (int a = 0; a < 512; a++) rd(9'(a));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/bram_loader.md
Name: bram_loader

Overview:
- Write-side counterpart to the block-RAM ROM readers. Accepts a byte stream over a valid/ready handshake and writes it into one SB_RAM40_4K. The RAM is configured 512x8, with WRITE_MODE=1 and READ_MODE=1.
- Writes go to consecutive addresses from a programmed base. Length is programmable per transfer.
- A registered read port exposes the same RAM, so lookup logic and benches can read back what was loaded.

Parameters:
- INIT_FILL, 8'h00, byte value replicated into all INIT_0..INIT_F contents at configuration.
- ADDR_W, 9, address width. Fixed by 512x8 mode; not to be overridden.

Ports:
- clk  in  1  single clock, drives both RCLK and WCLK.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; begins a transfer when IDLE.
- base_addr  in  9  first write address, sampled on accepted start.
- length  in  10  byte count 0..512, sampled on accepted start.
- abort  in  1  terminates a transfer immediately.
- in_data  in  8  byte to write.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  loader accepts in_data this cycle.
- busy  out  1  high in LOAD and DONE states.
- done  out  1  one-cycle pulse after the last byte is written.
- count  out  10  bytes written in the current/last transfer.
- raddr  in  9  read address.
- rdata  out  8  RAM data at raddr, one cycle after raddr is presented.

Behaviour:
- Reset (rst_n low, async):
  - state=IDLE; in_ready=0, busy=0, done=0, count=0; internal write address=0.
  - RAM contents are not cleared.
  - rdata is undefined until the first read clock after reset.
- States:
  - IDLE:
    - start=1 latches base_addr into wptr, length into remaining, and clears count.
    - Next state is LOAD if length!=0, else DONE.
  - LOAD:
    - in_ready=1.
    - A byte is accepted when in_valid&in_ready. The same edge performs WE=1, WADDR=wptr, WDATA=in_data.
    - On accept: wptr<=wptr+1 (mod 512, 511 wraps to 0); count+1; remaining-1.
    - Accept with remaining==1 moves to DONE. in_ready is 0 in the following cycle.
  - DONE: done=1 for exactly one cycle, then IDLE.
- abort:
  - In LOAD: moves to IDLE next edge without a done pulse. A byte offered in the same cycle is not written. count holds its value.
  - abort in IDLE or DONE is ignored.
  - abort and start together in IDLE: abort has priority and the transfer is not started.
- start outside IDLE is ignored; no restart and no latching.
- length>512 is illegal. The implementation clamps it to 512.
- Byte mapping into the 16-bit primitive ports:
  - Byte bit i goes to WDATA[2i]. rdata bit i comes from RDATA[2i]. Odd bits are driven 0.
  - MASK is tied 0; it is unused in 8-bit mode.
  - RADDR={2'b0,raddr}; WADDR={2'b0,wptr}.
- Read port: RE=1, RCLKE=1 always. Latency is 1 clk from raddr to rdata, independent of the loader state.
- Read and write to the same address in the same cycle: rdata is undefined for that cycle. Later reads return the new byte.
- Throughput: one byte per clk when in_valid is held high. in_valid gaps stall without losing position.
- Reset asserted mid-LOAD:
  - Transfer is abandoned and no done pulse is issued.
  - Bytes already written remain in RAM.
  - A write edge coincident with reset assertion is not guaranteed.

Test Plan:
- Basic load:
  - Stimulus: start with base=0, length=16; stream bytes 0x00..0x0F with in_valid held high.
  - Required: 16 accepts on consecutive cycles; done pulse one cycle after the 16th accept; count=16.
  - Readback: raddr 0..15 returns 0x00..0x0F, each with 1-cycle latency.
- Wrap with stalls:
  - Stimulus: base=510, length=4, data A1,A2,A3,A4; toggle in_valid 1,0,1,1,0,1.
  - Required: bytes land at addresses 510, 511, 0, 1; exactly 4 writes; done pulses once.
- Zero length: start with length=0 -> no in_ready, no write; done one cycle later; count=0.
- Abort:
  - Stimulus: base=32, length=8; abort after 3 accepts while in_valid=1 with 0x55.
  - Required: IDLE next cycle, no done, count=3; address 35 is not written (still holds its prior value).
- Reset and priority:
  - Async rst_n low mid-LOAD -> outputs reach reset values without a clock; written bytes preserved on readback.
  - start+abort together in IDLE -> stays IDLE.
  - start while busy -> ignored.
